ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Parametrised, pipelined extension unit; successor to the combinational immediate extender.
- One unit covers both extension jobs in the CPU datapath:
  - immediate extension for the ALU operand and LUI in the decode/execute path;
  - sub-word load-data extension (LB/LBU/LH/LHU) in the memory-writeback path.
- Result is registered through STAGES pipeline slots with valid/ready flow control, so it can sit across a stage boundary and absorb stalls.

Parameters:
- DATA_W, 32, width of in_data and out_data (multiple of 16, ≥32).
- IMM_W, 16, width of the immediate field used by modes 0-2 (IMM_W < DATA_W).
- STAGES, 1, number of register slots between input and output (legal 1-4).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  DATA_W  immediate (low IMM_W bits) or loaded word.
- in_mode  input  3  extension mode, decoded as listed under Behaviour.
- in_off  input  2  byte offset within the word for sub-word modes.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  extended result.
- flush  input  1  present only with EXT_FLUSH_EN.

Behaviour:
- Mode decode (combinational, before slot 1):
  - 0: zero-extend in_data[IMM_W-1:0].
  - 1: sign-extend in_data[IMM_W-1:0].
  - 2: LUI, {in_data[IMM_W-1:0], zeros} placed in the top IMM_W bits.
  - 3: zero-extend byte in_data[8*in_off +: 8].
  - 4: sign-extend that byte.
  - 5: zero-extend halfword in_data[16*in_off[1] +: 16]; in_off[0] ignored.
  - 6: sign-extend that halfword.
  - 7: pass in_data unchanged.
- Pipeline storage: slots 1..STAGES, each holding one valid bit and a DATA_W data register.
- Slot k ready_k = !valid_k || ready_{k+1}; ready_{STAGES+1} = out_ready.
- Transfers:
  - in_ready = ready_1.
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Slot update:
  - Slot k loads from slot k-1 (slot 1 loads from the decode result) when ready_k.
  - valid_k takes the upstream valid on that edge.
  - When !ready_k the slot holds: data stable, valid stable.
- out_valid = valid_STAGES; out_data = data_STAGES.
- Latency and throughput:
  - Exactly STAGES cycles from input transfer to out_valid with no backpressure.
  - Sustained throughput 1 per cycle with out_ready held high.
  - Zero bubbles inserted; ordering strictly FIFO.
- Backpressure: out_ready low with all slots full gives in_ready = 0 in the same cycle (combinational ready chain, no skid buffer).
- Simultaneous events: full pipe with out_ready = 1 and in_valid = 1 performs input and output transfer in the same cycle.
- Stability: in_valid may drop without a transfer; out_data and out_valid stay stable while out_valid && !out_ready.
- Reset (async assert, sync release):
  - All valid bits = 0, all data registers = 0.
  - Outputs: out_valid = 0, out_data = 0, in_ready = 1.
  - Reset mid-operation discards every in-flight result.
- STAGES outside 1-4, or IMM_W ≥ DATA_W: elaboration error, via a generate-time check.

Optional Feature:
- Macro: EXT_FLUSH_EN.
- With the macro:
  - flush port exists.
  - flush = 1 at a clock edge clears all valid bits; data registers are untouched.
  - An input offered in the same cycle is dropped; in_ready still reads 1 during flush.
  - Used on branch mispredict / exception squash.
- Without the macro: no flush port; valids change only through the normal handshake or reset.

Test Plan:
- Reset and mode sweep, STAGES=1, DATA_W=32, out_ready=1:
  - after reset_n low then high: out_valid=0, out_data=0, in_ready=1;
  - in_data=0x0000_8001, mode 0/1/2/7 one cycle later → 0x0000_8001 / 0xFFFF_8001 / 0x8001_0000 / 0x0000_8001.
- Sub-word loads, in_data=0x80FF_7F01:
  - mode 4, off 1 → 0x0000_007F; mode 4, off 3 → 0xFFFF_FF80;
  - mode 3, off 2 → 0x0000_00FF;
  - mode 6, off 2 → 0xFFFF_80FF; mode 5, off 1 → 0x0000_7F01.
- Streaming, STAGES=3, out_ready=1:
  - 8 back-to-back requests (mode 7, data 1..8);
  - first out_valid 3 cycles after first accept, then 8 consecutive results 1..8, in_ready never 0.
- Backpressure, STAGES=2:
  - out_ready=0 for 5 cycles while streaming: after 2 accepts in_ready=0, out_data held at first value;
  - out_ready=1 resumes: no loss or duplication; sequence 1..N intact.
- Async reset mid-stream, STAGES=4:
  - reset_n pulsed low between edges with 3 valid slots: out_valid falls immediately, no stale result after release;
  - next request emerges after 4 cycles.
- EXT_FLUSH_EN, STAGES=3:
  - flush for one cycle with 3 results in flight plus in_valid=1: out_valid=0 next cycle, none of the 4 appear;
  - the following request appears 3 cycles later.

Source files
------------

// File: rtl/ext_pipe.sv
// ext_pipe -- pipelined immediate / sub-word load-data extension unit.
//
// One decode stage (combinational), followed by STAGES register slots with
// valid/ready flow control. Each slot holds one valid bit and one data word.
// Ready is a purely combinational chain from out_ready back to in_ready.
// There is no skid buffer, so a full pipe with out_ready low stalls the input
// in the same cycle.
//
// Parameters:
//   DATA_W  data width (multiple of 16, >= 32)
//   IMM_W   immediate field width for modes 0-2 (< DATA_W)
//   STAGES  number of register slots, 1..4
//
// Ports:
//   clk        rising-edge clock
//   reset_n    async active-low reset; clears all valid bits and data
//   in_valid   request valid
//   in_ready   unit accepts a request this cycle
//   in_data    immediate (low IMM_W bits) or loaded word
//   in_mode    0 zext imm, 1 sext imm, 2 LUI, 3/4 zext/sext byte,
//              5/6 zext/sext halfword, 7 pass-through
//   in_off     byte offset for sub-word modes (halfword uses in_off[1])
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   extended result
//   flush      (EXT_FLUSH_EN only) clears every valid bit and drops the
//              input offered in the same cycle
//
// Optional feature macro: EXT_FLUSH_EN

module ext_pipe_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld,
  input  logic         clr,
  input  logic         d_vld,
  input  logic [W-1:0] d_dat,
  output logic         q_vld,
  output logic [W-1:0] q_dat
);
  // A flush only squashes the valid bit; data stays as it was.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_vld <= 1'b0;
      q_dat <= '0;
    end else if (clr) begin
      q_vld <= 1'b0;
    end else if (ld) begin
      q_vld <= d_vld;
      q_dat <= d_dat;
    end
  end
endmodule

module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  input  logic [1:0]        in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef EXT_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  generate
    if (STAGES < 1 || STAGES > 4 || IMM_W >= DATA_W || IMM_W < 1 ||
        DATA_W < 32 || (DATA_W % 16) != 0) begin : g_bad_param
      $error("ext_pipe: illegal parameter combination");
    end
  endgenerate

  logic flush_i;
`ifdef EXT_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // ---------------------------------------------------------------- decode
  logic [IMM_W-1:0]  imm;
  logic [7:0]        sub_b;
  logic [15:0]       sub_h;
  logic [DATA_W-1:0] dec;

  assign imm   = in_data[IMM_W-1:0];
  // Sub-word selects only ever reach into the low 32 bits of the word.
  assign sub_b = in_data[{in_off, 3'b000} +: 8];
  assign sub_h = in_data[{in_off[1], 4'b0000} +: 16];

  always_comb begin
    dec = '0;
    case (in_mode)
      3'd0:    dec = DATA_W'(imm);
      3'd1:    dec = DATA_W'($signed(imm));
      3'd2:    dec = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3:    dec = DATA_W'(sub_b);
      3'd4:    dec = DATA_W'($signed(sub_b));
      3'd5:    dec = DATA_W'(sub_h);
      3'd6:    dec = DATA_W'($signed(sub_h));
      default: dec = in_data;
    endcase
  end

  // -------------------------------------------------------------- pipeline
  // Index 0 is the decode result; 1..STAGES are the register slots.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;
  logic [STAGES+1:1]           rdy;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = dec;

  // Slot k can take a new entry if it is empty or the slot above is moving.
  always_comb begin
    rdy           = '0;
    rdy[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      rdy[k] = !vld_pipe[k] || rdy[k+1];
    end
  end

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_slot
      ext_pipe_slot #(.W(DATA_W)) u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .ld      (rdy[k]),
        .clr     (flush_i),
        .d_vld   (vld_pipe[k-1]),
        .d_dat   (dat_pipe[k-1]),
        .q_vld   (vld_pipe[k]),
        .q_dat   (dat_pipe[k])
      );
    end
  endgenerate

  // During a flush the offered input is dropped anyway, so advertise ready
  // to let the producer retire it.
  assign in_ready  = rdy[1] || flush_i;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: four instances (STAGES = 1..4), directed
// scenarios plus randomized traffic checked against a queue-based model.
module tb_ext_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       iv, ordy;
  logic [3:0][31:0] id;
  logic [3:0][2:0]  im;
  logic [3:0][1:0]  io;
  wire  [3:0]       ir, ov;
  wire  [3:0][31:0] od;
`ifdef EXT_FLUSH_EN
  logic [3:0]       fl;
`endif

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      ext_pipe #(.DATA_W(32), .IMM_W(16), .STAGES(g+1)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv[g]),
        .in_ready  (ir[g]),
        .in_data   (id[g]),
        .in_mode   (im[g]),
        .in_off    (io[g]),
        .out_valid (ov[g]),
        .out_ready (ordy[g]),
        .out_data  (od[g])
`ifdef EXT_FLUSH_EN
        ,
        .flush     (fl[g])
`endif
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: extension rules written as plain arithmetic on the word.
  function automatic int unsigned ext_ref(int unsigned d, int m, int o);
    int unsigned b, h, i;
    b = (d >> (8 * o)) & 255;
    h = (d >> (16 * (o / 2))) & 65535;
    i = d & 65535;
    case (m)
      0: return i;
      1: return (i >= 32768) ? i - 65536 : i;
      2: return i << 16;
      3: return b;
      4: return (b >= 128) ? b - 256 : b;
      5: return h;
      6: return (h >= 32768) ? h - 65536 : h;
      default: return d;
    endcase
  endfunction

  // One clock cycle on instance g. Entered and left at posedge+1.
  task automatic step(input int g, input bit v, input int unsigned d, input int m,
                      input int o, input bit r, input bit f, output bit acc);
    bit tin, tout;
    int unsigned e;
    iv[g] = v; id[g] = d; im[g] = 3'(m); io[g] = 2'(o); ordy[g] = r;
`ifdef EXT_FLUSH_EN
    fl[g] = f;
`endif
    @(negedge clk);
    // in_ready is out_ready or any slot free (or a flush in progress).
    chk("in_ready", 32'(ir[g]), 32'(r || q.size() < g + 1 || f));
    tin  = iv[g] && ir[g];
    tout = ov[g] && ordy[g];
    if (tout) begin
      if (q.size() == 0) chk("spurious_out", 32'(ov[g]), 32'd0);
      else begin
        e = q.pop_front();
        chk("out_data", od[g], e);
      end
    end
    if (f) q.delete();
    else if (tin) q.push_back(ext_ref(d, m, o));
    acc = tin && !f;
    @(posedge clk); #1;
`ifdef EXT_FLUSH_EN
    fl[g] = 1'b0;
`endif
  endtask

  task automatic drain(input int g);
    bit acc;
    for (int k = 0; k < 10 && q.size() > 0; k++) step(g, 0, 0, 0, 0, 1, 0, acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  int unsigned sw_d[9] = '{32'h0000_8001, 32'h0000_8001, 32'h0000_8001, 32'h0000_8001,
                           32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                           32'h80FF_7F01};
  int          sw_m[9] = '{0, 1, 2, 7, 4, 4, 3, 6, 5};
  int          sw_o[9] = '{0, 0, 0, 0, 1, 3, 2, 2, 1};
  int unsigned sw_e[9] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'h0000_8001,
                           32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                           32'h0000_7F01};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int unsigned nxt;
    iv = '0; ordy = '1; id = '0; im = '0; io = '0;
`ifdef EXT_FLUSH_EN
    fl = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rst_out_valid", 32'(ov[g]), 32'd0);
      chk("rst_out_data",  od[g],      32'd0);
      chk("rst_in_ready",  32'(ir[g]), 32'd1);
    end
    @(posedge clk); #1;

    // Mode sweep, STAGES=1: each result visible one cycle after its accept.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, sw_d[i], sw_m[i], sw_o[i], 1, 0, acc);
      chk("sweep_valid", 32'(ov[0]), 32'd1);
      chk("sweep_data",  od[0],      sw_e[i]);
    end
    drain(0);
    chk("sweep_idle", 32'(ov[0]), 32'd0);

    // Streaming, STAGES=3: 8 back-to-back, first result 3 cycles later.
    for (int i = 0; i < 16; i++) begin
      step(2, i < 8, i + 1, 7, 0, 1, 0, acc);
      chk("stream_valid", 32'(ov[2]), 32'((i + 1) >= 3 && (i + 1) <= 10));
      if ((i + 1) >= 3 && (i + 1) <= 10) chk("stream_data", od[2], 32'(i - 1));
    end
    drain(2);

    // Backpressure, STAGES=2.
    nxt = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, nxt, 7, 0, 0, 0, acc);
      if (acc) nxt++;
    end
    chk("bp_accepts",  nxt - 1,    32'd2);
    chk("bp_in_ready", 32'(ir[1]), 32'd0);
    chk("bp_hold_vld", 32'(ov[1]), 32'd1);
    chk("bp_hold_dat", od[1],      32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, nxt, 7, 0, 1, 0, acc);
      if (acc) nxt++;
    end
    drain(1);

    // Async reset mid-stream, STAGES=4.
    for (int i = 0; i < 4; i++) step(3, i < 3, 32'hA0 + i, 7, 0, 1, 0, acc);
    chk("pre_rst_valid", 32'(ov[3]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov[3]), 32'd0);
    chk("midrst_data",  od[3],      32'd0);
    chk("midrst_ready", 32'(ir[3]), 32'd1);
    q.delete();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      step(3, 0, 0, 0, 0, 1, 0, acc);
      chk("post_rst_stale", 32'(ov[3]), 32'd0);
    end
    step(3, 1, 32'h1234_8765, 1, 0, 1, 0, acc);
    for (int k = 1; k <= 4; k++) begin
      chk("rst_lat_valid", 32'(ov[3]), 32'(k == 4));
      if (k == 4) chk("rst_lat_data", od[3], 32'hFFFF_8765);
      step(3, 0, 0, 0, 0, 1, 0, acc);
    end
    drain(3);

`ifdef EXT_FLUSH_EN
    // Flush, STAGES=3: three in flight plus one offered, all squashed.
    for (int i = 0; i < 3; i++) step(2, 1, 32'hB0 + i, 7, 0, 1, 0, acc);
    step(2, 1, 32'hBF, 7, 0, 0, 1, acc);
    chk("flush_valid", 32'(ov[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(2, 0, 0, 0, 0, 1, 0, acc);
      chk("flush_none", 32'(ov[2]), 32'd0);
    end
    step(2, 1, 32'hC3, 7, 0, 1, 0, acc);
    for (int k = 1; k <= 3; k++) begin
      chk("flush_lat_valid", 32'(ov[2]), 32'(k == 3));
      if (k == 3) chk("flush_lat_data", od[2], 32'hC3);
      step(2, 0, 0, 0, 0, 1, 0, acc);
    end
    drain(2);
`endif

    // Randomized traffic on every depth against the queue model.
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 150; i++)
        step(g, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 2) != 0, 0, acc);
      drain(g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
